// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: wait-stated synchronous RAM access with an R-bit handshake.
// Define LC3_MMIO_EN to map xFE00-xFFFF to keyboard/display device registers.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_Reset_n,
    input  logic        i_MIO_EN,
    input  logic        i_R_W,
    input  logic [15:0] i_MAR,
    input  logic [15:0] i_MDR,
    output logic        o_Ready_Bit,
    output logic [15:0] o_rdata,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_kb_strobe,
    input  logic [7:0]  i_kb_data,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data,
    input  logic        i_dsp_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rw_q;
    logic        req_dev;
    logic        cur_dev;
    logic [15:0] dev_rdata;

`ifdef LC3_MMIO_EN
    logic       kb_rdy_q;
    logic [7:0] kbdr_q;
    logic       dsp_valid_q;
    logic [7:0] dsp_data_q;

    assign req_dev     = (i_MAR[15:9] == 7'h7F);
    assign cur_dev     = (o_mem_addr[15:9] == 7'h7F);
    assign o_dsp_valid = dsp_valid_q;
    assign o_dsp_data  = dsp_data_q;

    always_comb begin
        dev_rdata = '0;
        unique case (o_mem_addr)
            16'hFE00: dev_rdata = {kb_rdy_q, 15'b0};
            16'hFE02: dev_rdata = {8'b0, kbdr_q};
            16'hFE04: dev_rdata = {~dsp_valid_q, 15'b0};
            default:  dev_rdata = '0;
        endcase
    end
`else
    logic unused_dev;

    assign req_dev     = 1'b0;
    assign cur_dev     = 1'b0;
    assign dev_rdata   = '0;
    assign o_dsp_valid = 1'b0;
    assign o_dsp_data  = '0;
    assign unused_dev  = ^{i_kb_strobe, i_kb_data, i_dsp_ack};
`endif

    always_ff @(posedge i_clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            o_Ready_Bit <= 1'b0;
            o_rdata     <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
`ifdef LC3_MMIO_EN
            kb_rdy_q    <= 1'b0;
            kbdr_q      <= '0;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= '0;
`endif
        end else begin
            // Strobes and R are one-cycle pulses; only the entering transition raises them.
            o_Ready_Bit <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_MIO_EN) begin
                        state_q     <= ACCESS;
                        o_mem_addr  <= i_MAR;
                        o_mem_wdata <= i_MDR;
                        rw_q        <= i_R_W;
                        o_mem_en    <= ~req_dev;
                        o_mem_we    <= i_R_W & ~req_dev;
                    end
                end
                ACCESS: begin
                    if (cur_dev) begin
                        state_q     <= DONE;
                        o_Ready_Bit <= 1'b1;
                        if (!rw_q) o_rdata <= dev_rdata;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= WAIT_LAST;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= DONE;
                        o_Ready_Bit <= 1'b1;
                        if (!rw_q) o_rdata <= i_mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
`ifdef LC3_MMIO_EN
            if (state_q == ACCESS && rw_q && o_mem_addr == 16'hFE06) begin
                dsp_data_q  <= o_mem_wdata[7:0];
                dsp_valid_q <= 1'b1;
            end else if (i_dsp_ack) begin
                dsp_valid_q <= 1'b0;
            end
            // A keyboard strobe outranks the read-clear of KBSR in the same cycle.
            if (i_kb_strobe) begin
                kb_rdy_q <= 1'b1;
                kbdr_q   <= i_kb_data;
            end else if (state_q == DONE && !rw_q && o_mem_addr == 16'hFE02) begin
                kb_rdy_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, memory wait states per RAM access; legal range 1..15.
REQ-002 i_clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 i_Reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_MIO_EN  in  1  memory request from the control logic.
REQ-005 i_R_W  in  1  1 = write, 0 = read.
REQ-006 i_MAR  in  16  access address.
REQ-007 i_MDR  in  16  write data.
REQ-008 o_Ready_Bit  out  1  R bit to the microsequencer; access complete.
REQ-009 o_rdata  out  16  read data for the MDR load.
REQ-010 o_mem_en, o_mem_we  out  1 each  synchronous RAM strobes.
REQ-011 o_mem_addr, o_mem_wdata  out  16 each; i_mem_rdata  in  16, valid one cycle after o_mem_en.
REQ-012 i_kb_strobe  in  1; i_kb_data  in  8  new keyboard character.
REQ-013 o_dsp_valid  out  1; o_dsp_data  out  8; i_dsp_ack  in  1  display handshake.

Function
REQ-014 FSM states: IDLE, ACCESS, WAIT, DONE.
REQ-015 IDLE: if i_MIO_EN=1 at an edge, capture i_MAR, i_MDR, i_R_W and go to ACCESS.
REQ-016 ACCESS (one cycle): RAM address asserts o_mem_en=1 and o_mem_we=i_R_W with captured addr/data, then WAIT; device address drives no RAM strobe and goes to DONE.
REQ-017 WAIT: counter runs exactly WAIT_CYCLES cycles; o_rdata captures i_mem_rdata on a read at the final WAIT edge; then DONE.
REQ-018 DONE (one cycle): o_Ready_Bit=1, o_rdata stable; next state IDLE unconditionally.
REQ-019 o_Ready_Bit is 1 only in DONE.
REQ-020 Back-to-back requests see at least one IDLE cycle between DONE and the next ACCESS.
REQ-021 RAM latency: i_MIO_EN sampled at edge E0; R high in cycle WAIT_CYCLES+2 after E0. Device latency: R high in cycle 2.
REQ-022 i_MIO_EN, i_MAR and i_MDR are ignored outside IDLE; a transaction always completes, including the DONE pulse.
REQ-023 o_rdata holds its last value until the next read completes; writes do not change it.
REQ-024 o_mem_addr and o_mem_wdata show the captured values and hold them between transactions.

Reset
REQ-025 i_Reset_n=0 forces IDLE with counter=0 and all of the following: o_Ready_Bit=0, o_rdata=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, KBSR=0, KBDR=0, o_dsp_valid=0, o_dsp_data=0.
REQ-026 Reset asserted mid-transaction aborts it immediately; no R pulse follows, and the next request starts fresh from IDLE.

Configuration
REQ-027 Macro LC3_MMIO_EN defined: addresses xFE00-xFFFF are device space. KBSR=xFE00, KBDR=xFE02, DSR=xFE04, DDR=xFE06. Other device addresses read x0000 and ignore writes.
REQ-028 i_kb_strobe sets KBSR[15] and loads KBDR[7:0]. A strobe while KBSR[15]=1 overwrites KBDR.
REQ-029 A read of KBDR clears KBSR[15] in DONE. If a strobe arrives in the same cycle, the strobe wins and KBSR[15] stays 1.
REQ-030 DSR[15] = ~o_dsp_valid. A write to DDR loads o_dsp_data=i_MDR[7:0] and sets o_dsp_valid. o_dsp_valid clears on the cycle after i_dsp_ack=1. Writes to KBSR, KBDR and DSR are ignored.
REQ-031 Macro LC3_MMIO_EN undefined: no device space and no device registers. Every address, including xFE00-xFFFF, goes to RAM. o_dsp_valid and o_dsp_data are tied to 0, and i_kb_strobe, i_kb_data and i_dsp_ack are ignored.

Verification
REQ-032 WAIT_CYCLES=3; write x1234 to x3000 -> one-cycle o_mem_en=1 and o_mem_we=1 with addr x3000; o_Ready_Bit high in cycle 5 after the request edge, for exactly one cycle.
REQ-033 Read x3000 with i_mem_rdata=x1234 -> o_rdata=x1234 in DONE; o_mem_we=0; R high for one cycle.
REQ-034 LC3_MMIO_EN defined: i_kb_strobe with x41, then read xFE00 -> x8000, then read xFE02 -> x0041, then read xFE00 -> x0000; no RAM strobes occur.
REQ-035 LC3_MMIO_EN defined: write x0058 to xFE06 -> o_dsp_data=x58, o_dsp_valid=1, DSR reads x0000. Assert i_dsp_ack -> o_dsp_valid=0 and DSR reads x8000.
REQ-036 Drop i_Reset_n during WAIT -> all outputs return to reset values at once, no R pulse; the next read completes normally.
REQ-037 i_MIO_EN held high continuously -> DONE, IDLE, ACCESS sequence repeats and R pulses once per transaction.
